rm_violation_collector: RTL



---
 rtl/rm_violation_collector.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rm_violation_collector.sv
// Runtime-monitor violation collector: saturating per-rule hit counters, sticky
// per-rule flags and a timestamped event FIFO with a level interrupt.
module rm_violation_collector #(
    parameter int NumLanes  = 2,
    parameter int NumRules  = 4,
    parameter int CntWidth  = 16,
    parameter int FifoDepth = 8,
    localparam int RuleIdxW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumLanes-1:0][NumRules-1:0] monitor_i,
    input  logic                           clear_i,
    output logic                           evt_valid_o,
    input  logic                           evt_ready_i,
    output logic [NumLanes*NumRules-1:0]   evt_bits_o,
    output logic [31:0]                    evt_time_o,
    output logic [NumRules-1:0]            sticky_o,
    output logic                           overflow_o,
    input  logic [RuleIdxW-1:0]            rd_rule_i,
    output logic [CntWidth-1:0]            rd_cnt_o,
    output logic                           irq_o
);

    localparam int EvtW = NumLanes * NumRules;
    localparam int PtrW = $clog2(FifoDepth);
    localparam int HitW = $clog2(NumLanes + 1);
    localparam int SumW = CntWidth + HitW;
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [31:0]          stamp_q;
    logic [CntWidth-1:0]  cnt_q [NumRules];
    logic [CntWidth-1:0]  cnt_d [NumRules];
    logic [HitW-1:0]      hits  [NumRules];
    logic [SumW-1:0]      sum   [NumRules];
    logic [NumRules-1:0]  seen;
    logic [NumRules-1:0]  sticky_q;
    logic                 overflow_q;
    logic                 irq_q;

    logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
    logic [EvtW-1:0]      mem_bits [FifoDepth];
    logic [31:0]          mem_time [FifoDepth];

    logic empty, full, any_hit, pop_raw, pop, push, drop;

    // Per-rule popcount across lanes, then saturating accumulate.
    always_comb begin
        for (int r = 0; r < NumRules; r++) begin
            hits[r] = '0;
            for (int l = 0; l < NumLanes; l++) begin
                hits[r] = hits[r] + HitW'(monitor_i[l][r]);
            end
            seen[r]  = (hits[r] != '0);
            sum[r]   = SumW'(cnt_q[r]) + SumW'(hits[r]);
            cnt_d[r] = (sum[r] > SumW'(CntMax)) ? CntMax : sum[r][CntWidth-1:0];
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign any_hit = |monitor_i;
    assign pop_raw = !empty && evt_ready_i;
    // Clear wins over everything; a pop frees the slot for a same-cycle push.
    assign pop     = pop_raw && !clear_i;
    assign push    = any_hit && !clear_i && (!full || pop_raw);
    assign drop    = any_hit && !clear_i && full && !pop_raw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
            for (int r = 0; r < NumRules; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
            for (int r = 0; r < NumRules; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
            sticky_q <= sticky_q | seen;
            for (int r = 0; r < NumRules; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_bits[wr_ptr_q[PtrW-1:0]] <= monitor_i;
            mem_time[wr_ptr_q[PtrW-1:0]] <= stamp_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= evt_valid_o | overflow_q;
        end
    end

    always_comb begin
        rd_cnt_o = '0;
        for (int r = 0; r < NumRules; r++) begin
            if (int'(rd_rule_i) == r) rd_cnt_o = cnt_q[r];
        end
    end

    assign evt_valid_o = !empty;
    assign evt_bits_o  = empty ? '0 : mem_bits[rd_ptr_q[PtrW-1:0]];
    assign evt_time_o  = empty ? '0 : mem_time[rd_ptr_q[PtrW-1:0]];
    assign sticky_o    = sticky_q;
    assign overflow_o  = overflow_q;
    assign irq_o       = irq_q;

endmodule
